prog_loader_mem: RTL and testbench

//   Instruction memory for the microprocessor, serving the far end of its fetch interface.
//   The CPU drives address[7:0]; this block returns instruction[7:0] combinationally, so a

---
 rtl/prog_loader_mem.sv | 147 ++++++++++++++
 tb/tb_prog_loader_mem.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader_mem.sv
// prog_loader_mem
//   Instruction memory at the far end of the CPU fetch interface. A program is
//   streamed in one byte at a time over a valid/ready load port. The CPU is
//   held in reset while loading and for RST_HOLD cycles afterwards. It is then
//   released, and fetches are answered combinationally from the stored bytes.
//
// Handshake: a byte transfers on a rising edge where load_valid && load_ready.
//   The load_ready output is a decode of the registered state. It never depends
//   on load_valid. A load_start in the same cycle overrides the transfer, so that
//   byte is discarded.
//
// Ports
//   _clk         in   1  system clock, rising edge
//   reset        in   1  asynchronous, active-low reset
//   load_start   in   1  begin a new program load (restarts any load in progress)
//   load_valid   in   1  load_data/load_last valid
//   load_data    in   8  program byte
//   load_last    in   1  final byte of the program
//   load_ready   out  1  byte can be accepted (LOAD state)
//   address      in   8  CPU fetch address
//   instruction  out  8  instruction at address, or FILL
//   cpu_reset    out  1  active-high CPU reset (every state except RUN)
//   load_done    out  1  program loaded and CPU running
//   prog_len     out  9  bytes in the current program
//   err_drop     out  1  sticky: a byte was offered outside LOAD
module prog_loader_mem #(
    parameter int unsigned DEPTH    = 32,
    parameter logic [7:0]  FILL     = 8'h00,
    parameter int unsigned RST_HOLD = 4
) (
    input  logic       _clk,
    input  logic       reset,
    input  logic       load_start,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    input  logic       load_last,
    output logic       load_ready,
    input  logic [7:0] address,
    output logic [7:0] instruction,
    output logic       cpu_reset,
    output logic       load_done,
    output logic [8:0] prog_len,
    output logic       err_drop
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);
    localparam logic [8:0]    DEPTH_W   = 9'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2,
        ST_RUN  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [8:0]    wr_ptr_q, wr_ptr_d;
    logic [8:0]    prog_len_q, prog_len_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          err_drop_q, err_drop_d;
    logic          mem_we;
    logic          in_range;

    logic [7:0] mem [DEPTH];

    always_ff @(posedge _clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            prog_len_q <= '0;
            hold_cnt_q <= '0;
            err_drop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            prog_len_q <= prog_len_d;
            hold_cnt_q <= hold_cnt_d;
            err_drop_q <= err_drop_d;
        end
    end

    // Storage has no reset. A prog_len of 0 hides stale contents from the read path.
    always_ff @(posedge _clk) begin
        if (mem_we) begin
            mem[wr_ptr_q[AW-1:0]] <= load_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        prog_len_d = prog_len_q;
        hold_cnt_d = hold_cnt_q;
        err_drop_d = err_drop_q;
        mem_we     = 1'b0;

        if (load_start) begin
            // Restart from any state. A byte offered in the same cycle is
            // discarded and is not reported as a drop.
            state_d    = ST_LOAD;
            wr_ptr_d   = '0;
            prog_len_d = '0;
            hold_cnt_d = '0;
            err_drop_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_LOAD: begin
                    if (load_valid) begin
                        mem_we     = 1'b1;
                        wr_ptr_d   = wr_ptr_q + 9'd1;
                        prog_len_d = prog_len_q + 9'd1;
                        // Filling the last slot ends the load even without load_last.
                        if (load_last || (wr_ptr_q + 9'd1 == DEPTH_W)) begin
                            state_d    = ST_HOLD;
                            hold_cnt_d = '0;
                        end
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HW'(1);
                    end
                end
                default: begin
                end
            endcase
            if (load_valid && (state_q != ST_LOAD)) begin
                err_drop_d = 1'b1;
            end
        end
    end

    assign load_ready = (state_q == ST_LOAD);
    assign cpu_reset  = (state_q != ST_RUN);
    assign load_done  = (state_q == ST_RUN);
    assign prog_len   = prog_len_q;
    assign err_drop   = err_drop_q;

    // The full 8-bit address is compared, so high addresses never alias into memory.
    assign in_range    = (state_q == ST_RUN) && ({1'b0, address} < prog_len_q);
    assign instruction = in_range ? mem[address[AW-1:0]] : FILL;

endmodule

// File: tb/tb_prog_loader_mem.sv
// tb_prog_loader_mem
//   Bench for prog_loader_mem. A reference model advances once per rising edge.
//   It tracks program bytes in an array, the load phase as a small integer, and
//   the CPU release time as an absolute cycle number.
module tb_prog_loader_mem;

    localparam int         DEPTH    = 32;
    localparam logic [7:0] FILL     = 8'hA5;
    localparam int         RST_HOLD = 4;

    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_HOLD = 2;
    localparam int PH_RUN  = 3;

    logic       _clk = 1'b0;
    logic       reset = 1'b1;
    logic       load_start = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = 8'h00;
    logic       load_last = 1'b0;
    logic [7:0] address = 8'h00;
    logic       load_ready;
    logic [7:0] instruction;
    logic       cpu_reset;
    logic       load_done;
    logic [8:0] prog_len;
    logic       err_drop;
    logic [20:0] obs;

    int n_checks = 0;
    int n_fails  = 0;

    // reference model state
    logic [7:0] m_mem [256];
    int         m_len;
    int         m_phase;
    bit         m_err;
    int         m_cyc = 0;
    int         m_release_at;

    prog_loader_mem #(.DEPTH(DEPTH), .FILL(FILL), .RST_HOLD(RST_HOLD)) dut (
        ._clk        (_clk),
        .reset       (reset),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .address     (address),
        .instruction (instruction),
        .cpu_reset   (cpu_reset),
        .load_done   (load_done),
        .prog_len    (prog_len),
        .err_drop    (err_drop)
    );

    assign obs = {load_ready, cpu_reset, load_done, prog_len, err_drop, instruction};

    always #5 _clk = ~_clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    task automatic model_reset();
        m_phase = PH_IDLE;
        m_len   = 0;
        m_err   = 1'b0;
    endtask

    task automatic model_edge();
        m_cyc++;
        if (load_start) begin
            m_phase = PH_LOAD;
            m_len   = 0;
            m_err   = 1'b0;
        end else if (m_phase == PH_LOAD) begin
            if (load_valid) begin
                m_mem[m_len] = load_data;
                m_len++;
                if (load_last || m_len == DEPTH) begin
                    m_phase      = PH_HOLD;
                    m_release_at = m_cyc + RST_HOLD;
                end
            end
        end else begin
            if (load_valid) m_err = 1'b1;
            if (m_phase == PH_HOLD && m_cyc == m_release_at) m_phase = PH_RUN;
        end
    endtask

    function automatic logic [20:0] exp_vec();
        logic [7:0] ins;
        ins = (m_phase == PH_RUN && int'(address) < m_len) ? m_mem[address] : FILL;
        return {m_phase == PH_LOAD, m_phase != PH_RUN, m_phase == PH_RUN, 9'(m_len), m_err, ins};
    endfunction

    // ---------------- driver ----------------
    // Applies inputs for one cycle, advances the model on the edge, and returns 1ns after it.
    task automatic drive(input bit st, input bit v, input logic [7:0] d, input bit l);
        load_start = st;
        load_valid = v;
        load_data  = d;
        load_last  = l;
        @(posedge _clk);
        model_edge();
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        address = 8'h00;
        reset = 1'b1;
        #1 reset = 1'b0;
        model_reset();
        #100;
        n_checks++;
        if (obs !== exp_vec()) begin
            n_fails++;
            $display("FAIL reset_model: got %h exp %h", obs, exp_vec());
        end
        n_checks++;
        if ({instruction, cpu_reset, load_ready, prog_len, err_drop, load_done} !==
            {FILL, 1'b1, 1'b0, 9'd0, 1'b0, 1'b0}) begin
            n_fails++;
            $display("FAIL reset_values: ins=%h cpu_reset=%b ready=%b len=%0d err=%b done=%b",
                     instruction, cpu_reset, load_ready, prog_len, err_drop, load_done);
        end
        @(negedge _clk) reset = 1'b1;
    endtask

    task automatic test_basic_load();
        logic [7:0] prog [4];
        int cnt;
        prog[0] = 8'h44; prog[1] = 8'h49; prog[2] = 8'h19; prog[3] = 8'h84;
        drive(1, 0, 8'h00, 0);
        n_checks++;
        if (obs !== exp_vec()) begin
            n_fails++;
            $display("FAIL basic_start: got %h exp %h", obs, exp_vec());
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, prog[i], i == 3);
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fails++;
                $display("FAIL basic_byte%0d: got %h exp %h", i, obs, exp_vec());
            end
        end
        cnt = 0;
        while (cpu_reset === 1'b1 && cnt < 20) begin
            drive(0, 0, 8'h00, 0);
            cnt++;
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fails++;
                $display("FAIL basic_hold: got %h exp %h", obs, exp_vec());
            end
        end
        n_checks++;
        if (cnt !== RST_HOLD) begin
            n_fails++;
            $display("FAIL basic_release_latency: got %0d cycles exp %0d", cnt, RST_HOLD);
        end
        address = 8'd2;
        #1;
        n_checks++;
        if (instruction !== 8'h19 || prog_len !== 9'd4) begin
            n_fails++;
            $display("FAIL basic_read2: ins=%h len=%0d exp ins=19 len=4", instruction, prog_len);
        end
        address = 8'd4;
        #1;
        n_checks++;
        if (instruction !== FILL) begin
            n_fails++;
            $display("FAIL basic_read4: ins=%h exp %h", instruction, FILL);
        end
    endtask

    task automatic test_auto_hold();
        logic [7:0] last_byte;
        int cnt;
        drive(1, 0, 8'h00, 0);
        for (int i = 0; i < DEPTH; i++) begin
            last_byte = 8'($urandom);
            drive(0, 1, last_byte, 0);
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fails++;
                $display("FAIL auto_byte%0d: got %h exp %h", i, obs, exp_vec());
            end
        end
        n_checks++;
        if (load_ready !== 1'b0 || cpu_reset !== 1'b1 || prog_len !== 9'(DEPTH)) begin
            n_fails++;
            $display("FAIL auto_hold_entry: ready=%b cpu_reset=%b len=%0d exp 0/1/%0d",
                     load_ready, cpu_reset, prog_len, DEPTH);
        end
        drive(0, 1, 8'hFF, 0);
        n_checks++;
        if (err_drop !== 1'b1 || obs !== exp_vec()) begin
            n_fails++;
            $display("FAIL auto_err_drop: err=%b got %h exp %h", err_drop, obs, exp_vec());
        end
        cnt = 0;
        while (cpu_reset === 1'b1 && cnt < 20) begin
            drive(0, 0, 8'h00, 0);
            cnt++;
        end
        n_checks++;
        if (cpu_reset !== 1'b0) begin
            n_fails++;
            $display("FAIL auto_release_timeout: cpu_reset=%b exp 0", cpu_reset);
        end
        address = 8'(DEPTH - 1);
        #1;
        n_checks++;
        if (instruction !== last_byte || obs !== exp_vec()) begin
            n_fails++;
            $display("FAIL auto_read_last: ins=%h exp %h", instruction, last_byte);
        end
        address = 8'(DEPTH);
        #1;
        n_checks++;
        if (instruction !== FILL) begin
            n_fails++;
            $display("FAIL auto_read_oob: ins=%h exp %h", instruction, FILL);
        end
    endtask

    task automatic test_restart();
        logic [7:0] first;
        int cnt;
        drive(1, 0, 8'h00, 0);
        drive(0, 1, 8'h11, 0);
        drive(0, 1, 8'h22, 0);
        drive(1, 1, 8'h77, 0);
        n_checks++;
        if (err_drop !== 1'b0 || prog_len !== 9'd0 || load_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL restart_clear: err=%b len=%0d ready=%b exp 0/0/1",
                     err_drop, prog_len, load_ready);
        end
        n_checks++;
        if (obs !== exp_vec()) begin
            n_fails++;
            $display("FAIL restart_model: got %h exp %h", obs, exp_vec());
        end
        first = 8'h3C;
        drive(0, 1, first, 0);
        drive(0, 1, 8'h5A, 0);
        drive(0, 1, 8'h6B, 1);
        cnt = 0;
        while (cpu_reset === 1'b1 && cnt < 20) begin
            drive(0, 0, 8'h00, 0);
            cnt++;
        end
        address = 8'd0;
        #1;
        n_checks++;
        if (instruction !== first || prog_len !== 9'd3) begin
            n_fails++;
            $display("FAIL restart_read0: ins=%h len=%0d exp %h/3", instruction, prog_len, first);
        end
        address = 8'd3;
        #1;
        n_checks++;
        if (obs !== exp_vec()) begin
            n_fails++;
            $display("FAIL restart_read3: got %h exp %h", obs, exp_vec());
        end
    endtask

    task automatic test_run_reload();
        int cnt;
        address = 8'd0;
        drive(1, 0, 8'h00, 0);
        n_checks++;
        if (cpu_reset !== 1'b1 || instruction !== FILL || load_done !== 1'b0) begin
            n_fails++;
            $display("FAIL reload_enter: cpu_reset=%b ins=%h done=%b exp 1/%h/0",
                     cpu_reset, instruction, load_done, FILL);
        end
        drive(0, 1, 8'hC3, 0);
        drive(0, 0, 8'h00, 0);
        drive(0, 1, 8'hD4, 1);
        cnt = 0;
        while (cpu_reset === 1'b1 && cnt < 20) begin
            address = 8'd1;
            #1;
            n_checks++;
            if (instruction !== FILL) begin
                n_fails++;
                $display("FAIL reload_fill_in_hold: ins=%h exp %h", instruction, FILL);
            end
            drive(0, 0, 8'h00, 0);
            cnt++;
        end
        address = 8'd1;
        #1;
        n_checks++;
        if (instruction !== 8'hD4 || obs !== exp_vec()) begin
            n_fails++;
            $display("FAIL reload_read1: ins=%h exp D4", instruction);
        end
    endtask

    task automatic test_reset_midway();
        int cnt;
        drive(1, 0, 8'h00, 0);
        drive(0, 1, 8'h01, 0);
        drive(0, 1, 8'h02, 0);
        #2 reset = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({instruction, cpu_reset, load_ready, prog_len, err_drop} !==
            {FILL, 1'b1, 1'b0, 9'd0, 1'b0}) begin
            n_fails++;
            $display("FAIL reset_in_load: got %h exp %h", obs, exp_vec());
        end
        @(negedge _clk) reset = 1'b1;
        drive(1, 0, 8'h00, 0);
        drive(0, 1, 8'h9E, 1);
        cnt = 0;
        while (cpu_reset === 1'b1 && cnt < 20) begin
            drive(0, 0, 8'h00, 0);
            cnt++;
        end
        address = 8'd0;
        #1;
        n_checks++;
        if (instruction !== 8'h9E || obs !== exp_vec()) begin
            n_fails++;
            $display("FAIL reload_after_reset: ins=%h exp 9E", instruction);
        end
        #1 reset = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({instruction, cpu_reset, load_done, prog_len, err_drop} !==
            {FILL, 1'b1, 1'b0, 9'd0, 1'b0}) begin
            n_fails++;
            $display("FAIL reset_in_run: got %h exp %h", obs, exp_vec());
        end
        @(negedge _clk) reset = 1'b1;
    endtask

    task automatic test_random();
        for (int p = 0; p < 12; p++) begin
            int len;
            int sent;
            int budget;
            len = $urandom_range(1, DEPTH);
            drive(1, 0, 8'h00, 0);
            sent = 0;
            budget = 0;
            while (m_phase == PH_LOAD && budget < 400) begin
                budget++;
                if ($urandom_range(0, 3) == 0) begin
                    drive(0, 0, 8'($urandom), 1'($urandom));
                end else if ($urandom_range(0, 60) == 0) begin
                    drive(1, 1'($urandom), 8'($urandom), 0);
                    sent = 0;
                end else begin
                    drive(0, 1, 8'($urandom), (sent + 1 == len) && (len < DEPTH || 1'($urandom)));
                    sent++;
                end
                n_checks++;
                if (obs !== exp_vec()) begin
                    n_fails++;
                    $display("FAIL rand_load p=%0d cyc=%0d: got %h exp %h", p, m_cyc, obs, exp_vec());
                end
            end
            budget = 0;
            while (cpu_reset === 1'b1 && budget < 20) begin
                budget++;
                drive(0, ($urandom_range(0, 5) == 0), 8'($urandom), 0);
                n_checks++;
                if (obs !== exp_vec()) begin
                    n_fails++;
                    $display("FAIL rand_hold p=%0d cyc=%0d: got %h exp %h", p, m_cyc, obs, exp_vec());
                end
            end
            n_checks++;
            if (cpu_reset !== 1'b0) begin
                n_fails++;
                $display("FAIL rand_release_timeout p=%0d: cpu_reset=%b exp 0", p, cpu_reset);
            end
            for (int r = 0; r < 6; r++) begin
                drive(0, 0, 8'h00, 0);
                address = (r == 5) ? 8'($urandom) : 8'($urandom_range(0, DEPTH + 4));
                #1;
                n_checks++;
                if (obs !== exp_vec()) begin
                    n_fails++;
                    $display("FAIL rand_read p=%0d addr=%0d: got %h exp %h", p, address, obs, exp_vec());
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_load();
        test_auto_hold();
        test_restart();
        test_run_reload();
        test_reset_midway();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
